// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between the core datapaths, the DM arbiter and the DM block.
// master: the arbiter side. slave: the cores and DM side.
interface dm_port_arbiter_if #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int ID_W      = 2
);
   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES-1:0]        core_we;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES*DATA_W-1:0] core_wdata;
   logic [NUM_CORES-1:0]        core_ack;
   logic [DATA_W-1:0]           core_rdata;
   logic                        mem_en;
   logic                        mem_we;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic [DATA_W-1:0]           mem_rdata;
   logic                        busy;
   logic [ID_W-1:0]             grant_id;

   modport master (
      input  core_req, core_we, core_addr, core_wdata, mem_rdata,
      output core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata,
             busy, grant_id
   );

   modport slave (
      output core_req, core_we, core_addr, core_wdata, mem_rdata,
      input  core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata,
             busy, grant_id
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between cores.
// One grant at a time: latch request, strobe DM once, return data, ack.
//
// state  | meaning
// IDLE   | no access in flight; pick round-robin winner from core_req
// ISSUE  | mem_en strobe with latched we/addr/wdata
// RDWAIT | DM read data arrives; captured into core_rdata at end of cycle
// DONE   | one-cycle core_ack pulse to the granted core; advance rr_ptr
module dm_port_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int ID_W      = 2
) (
   input  logic               clk,
   input  logic               rst,
   dm_port_arbiter_if.master  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_RDWAIT = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]        state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_id;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;

   logic              win_hit;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   scan_id;

   // Scan requests starting at rr_ptr; first asserted request wins.
   always_comb begin
      win_hit = 1'b0;
      win_id  = '0;
      scan_id = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         scan_id = ID_W'((int'(rr_ptr) + i) % NUM_CORES);
         if (!win_hit && bus.core_req[scan_id]) begin
            win_hit = 1'b1;
            win_id  = scan_id;
         end
      end
   end

   // Sequencer state, grant latches, round-robin pointer and read capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_hit) begin
                  grant_id <= win_id;
                  we_q     <= bus.core_we[win_id];
                  addr_q   <= bus.core_addr[win_id*ADDR_W +: ADDR_W];
                  wdata_q  <= bus.core_wdata[win_id*DATA_W +: DATA_W];
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= we_q ? ST_DONE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
               rdata_q <= bus.mem_rdata;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               rr_ptr <= (grant_id == ID_W'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Ack pulse decoded from the DONE state and the latched grant.
   always_comb begin
      bus.core_ack = '0;
      if (state == ST_DONE) bus.core_ack[grant_id] = 1'b1;
   end

   // DM port and status decoded from registered state only.
   assign bus.mem_en     = (state == ST_ISSUE);
   assign bus.mem_we     = (state == ST_ISSUE) && we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.core_rdata = rdata_q;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.grant_id   = grant_id;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small registered DM model.
module tb_dm_port_arbiter;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_bad;

   dm_port_arbiter_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .ID_W(2)) bus ();

   dm_port_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .ID_W(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DM model: write on strobe, read data registered one cycle after strobe.
   logic [15:0] dm [0:255];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) dm[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= dm[bus.mem_addr[7:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise a request, wait for its ack (bounded), drop it, step past DONE.
   task automatic run_txn(input int k, input logic we, input logic [15:0] a,
                          input logic [15:0] d, output int lat);
      bus.core_req[k] = 1'b1;
      bus.core_we[k]  = we;
      bus.core_addr[k*16 +: 16]  = a;
      bus.core_wdata[k*16 +: 16] = d;
      lat = 0;
      while (bus.core_ack[k] !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      bus.core_req[k] = 1'b0;
      tick();
   endtask

   int lat;
   int g;
   int cyc;
   int en_cnt;
   int ack_cyc [0:3];
   logic [3:0] ack_val [0:3];
   logic [3:0] reraise;

   initial begin
      n_chk = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.core_req   = '0;
      bus.core_we    = '0;
      bus.core_addr  = '0;
      bus.core_wdata = '0;
      tick();
      tick();
      check("rst_busy",   bus.busy, 0);
      check("rst_grant",  bus.grant_id, 0);
      check("rst_ack",    bus.core_ack, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_rdata",  bus.core_rdata, 0);
      rst = 1'b0;
      tick();

      // single write, core 2
      bus.core_req[2] = 1'b1;
      bus.core_we[2]  = 1'b1;
      bus.core_addr[32 +: 16]  = 16'h0010;
      bus.core_wdata[32 +: 16] = 16'hBEEF;
      tick();
      check("wr_c1_en",    bus.mem_en, 1);
      check("wr_c1_we",    bus.mem_we, 1);
      check("wr_c1_addr",  bus.mem_addr, 16'h0010);
      check("wr_c1_wdata", bus.mem_wdata, 16'hBEEF);
      check("wr_c1_grant", bus.grant_id, 2);
      check("wr_c1_ack",   bus.core_ack, 0);
      tick();
      check("wr_c2_ack",   bus.core_ack, 4'b0100);
      check("wr_c2_en",    bus.mem_en, 0);
      check("wr_c2_we",    bus.mem_we, 0);
      bus.core_req[2] = 1'b0;
      tick();
      check("wr_c3_busy",  bus.busy, 0);
      check("wr_c3_ack",   bus.core_ack, 0);
      check("wr_dm",       dm[8'h10], 16'hBEEF);

      // preload DM[0x20] through core 0, then single read by core 1
      run_txn(0, 1'b1, 16'h0020, 16'h1234, lat);
      check("pre_lat", lat, 2);
      bus.core_req[1] = 1'b1;
      bus.core_we[1]  = 1'b0;
      bus.core_addr[16 +: 16] = 16'h0020;
      tick();
      check("rd_c1_en",   bus.mem_en, 1);
      check("rd_c1_we",   bus.mem_we, 0);
      check("rd_c1_addr", bus.mem_addr, 16'h0020);
      tick();
      check("rd_c2_ack",  bus.core_ack, 0);
      check("rd_c2_en",   bus.mem_en, 0);
      check("rd_c2_busy", bus.busy, 1);
      tick();
      check("rd_c3_ack",   bus.core_ack, 4'b0010);
      check("rd_c3_rdata", bus.core_rdata, 16'h1234);
      bus.core_req[1] = 1'b0;
      tick();
      check("rd_c4_busy", bus.busy, 0);

      // data hold: read 0x5555 then a write must leave core_rdata alone
      run_txn(2, 1'b1, 16'h0030, 16'h5555, lat);
      run_txn(0, 1'b0, 16'h0030, 16'h0000, lat);
      check("hold_rd_lat",   lat, 3);
      check("hold_rd_rdata", bus.core_rdata, 16'h5555);
      bus.core_req[1] = 1'b1;
      bus.core_we[1]  = 1'b1;
      bus.core_addr[16 +: 16]  = 16'h0040;
      bus.core_wdata[16 +: 16] = 16'hAAAA;
      lat = 0;
      while (bus.core_ack[1] !== 1'b1 && lat < 20) begin
         tick();
         lat++;
         check("hold_rdata", bus.core_rdata, 16'h5555);
      end
      check("hold_wr_lat", lat, 2);
      bus.core_req[1] = 1'b0;
      tick();
      check("hold_after", bus.core_rdata, 16'h5555);
      check("hold_dm",    dm[8'h40], 16'hAAAA);

      // reset in the RDWAIT cycle of a core 2 read
      bus.core_req[2] = 1'b1;
      bus.core_we[2]  = 1'b0;
      bus.core_addr[32 +: 16] = 16'h0030;
      tick();
      check("mr_issue_en", bus.mem_en, 1);
      tick();
      check("mr_rdwait_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check("mr_busy",  bus.busy, 0);
      check("mr_grant", bus.grant_id, 0);
      check("mr_ack",   bus.core_ack, 0);
      check("mr_en",    bus.mem_en, 0);
      check("mr_rdata", bus.core_rdata, 0);
      bus.core_req = '0;
      tick();
      check("mr_ack2",  bus.core_ack, 0);
      rst = 1'b0;
      tick();
      check("mr_ack3",  bus.core_ack, 0);
      run_txn(3, 1'b0, 16'h0010, 16'h0000, lat);
      check("mr_c3_lat",   lat, 3);
      check("mr_c3_rdata", bus.core_rdata, 16'hBEEF);
      check("mr_c3_grant", bus.grant_id, 3);

      // contention from reset: all four cores write at cycle 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         bus.core_we[k] = 1'b1;
         bus.core_addr[k*16 +: 16]  = 16'h0080 + 16'(k);
         bus.core_wdata[k*16 +: 16] = 16'hC000 + 16'(k);
      end
      bus.core_req = 4'b1111;
      g = 0;
      en_cnt = 0;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (bus.mem_en) en_cnt++;
         if (bus.core_ack != 4'b0000 && g < 4) begin
            ack_val[g] = bus.core_ack;
            ack_cyc[g] = c;
            g++;
            bus.core_req = bus.core_req & ~bus.core_ack;
         end
      end
      check("ct_grants", g, 4);
      check("ct_en_cnt", en_cnt, 4);
      for (int n = 0; n < 4; n++) begin
         if (n < g) begin
            check("ct_order", ack_val[n], 32'(4'b0001 << n));
            check("ct_cycle", ack_cyc[n], 2 + 3*n);
         end
      end
      for (int k = 0; k < 4; k++)
         check("ct_dm", dm[8'h80 + 8'(k)], 16'hC000 + 16'(k));

      // fairness: cores 0 and 3 re-request one cycle after each ack
      bus.core_req = 4'b1001;
      reraise = '0;
      g = 0;
      cyc = 0;
      while (g < 20 && cyc < 300) begin
         tick();
         cyc++;
         bus.core_req = bus.core_req | reraise;
         reraise = '0;
         if (bus.core_ack != 4'b0000) begin
            check("fair_seq", bus.core_ack, (g % 2 == 0) ? 4'b0001 : 4'b1000);
            g++;
            reraise = bus.core_ack;
            bus.core_req = bus.core_req & ~bus.core_ack;
         end
      end
      check("fair_grants", g, 20);
      bus.core_req = '0;
      tick();
      tick();
      tick();
      check("end_busy", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
